// File: rtl/uart_axil_regs.sv
// AXI4-Lite register block in front of the UART FIFOs: RXDATA, TXDATA, STATUS, CTRL.
// Define UART_AXIL_IRQ_MASK_EN to make CTRL[8] a writable interrupt enable.
module uart_axil_regs #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  rfifo_pop,
    input  logic [31:0]           rfifo_data_out,
    input  logic                  rx_empty,
    output logic                  tfifo_push,
    output logic [31:0]           tfifo_data_in,
    input  logic                  tx_full,
    output logic [31:0]           uart_fifo_ctrl,
    input  logic                  uart_irq,
    output logic                  irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Valid/ready: a channel transfers on the rising edge where both are high;
    // the sender holds payload stable until then, and every response is held until taken.
    logic                  bus_live;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [31:0]           w_data;
    logic [1:0]            w_strb;
    logic [2:0]            ctrl_mode;
    logic                  irq_en;

    logic                  wr_exec;
    logic [1:0]            wr_resp;
    logic                  wr_push;
    logic                  wr_ctrl;
    logic [31:0]           rd_data;
    logic [1:0]            rd_resp;
    logic                  rd_pop;
    logic [31:0]           ctrl_word;
    logic                  unused_bits;

    // Anything set above bit 3 lands outside the four-register window.
    function automatic logic is_unmapped(input logic [ADDR_WIDTH-1:0] a);
        return (a >> 4) != '0;
    endfunction

    assign s_awready      = bus_live && !aw_held && !s_bvalid;
    assign s_wready       = bus_live && !w_held && !s_bvalid;
    assign s_arready      = bus_live && !s_rvalid;
    assign wr_exec        = aw_held && w_held && !s_bvalid;
    assign uart_fifo_ctrl = {29'd0, ctrl_mode};
    assign ctrl_word      = {23'd0, irq_en, 5'd0, ctrl_mode};
    assign unused_bits    = ^{s_wstrb[3:2], w_strb[1], aw_addr[1:0], s_araddr[1:0]};

    always_comb begin
        wr_resp = RESP_OKAY;
        wr_push = 1'b0;
        wr_ctrl = 1'b0;
        if (is_unmapped(aw_addr)) begin
            wr_resp = RESP_DECERR;
        end else begin
            case (aw_addr[3:2])
                2'd0: wr_resp = RESP_SLVERR;
                2'd1: begin
                    if (tx_full) wr_resp = RESP_SLVERR;
                    else         wr_push = 1'b1;
                end
                2'd2: wr_resp = RESP_SLVERR;
                2'd3: wr_ctrl = 1'b1;
            endcase
        end
    end

    always_comb begin
        rd_data = 32'd0;
        rd_resp = RESP_OKAY;
        rd_pop  = 1'b0;
        if (is_unmapped(s_araddr)) begin
            rd_resp = RESP_DECERR;
        end else begin
            case (s_araddr[3:2])
                2'd0: begin
                    if (!rx_empty) begin
                        rd_data = rfifo_data_out;
                        rd_pop  = 1'b1;
                    end
                end
                2'd1: rd_resp = RESP_SLVERR;
                2'd2: rd_data = {29'd0, uart_irq, tx_full, rx_empty};
                2'd3: rd_data = ctrl_word;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_live      <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr       <= '0;
            w_data        <= 32'd0;
            w_strb        <= 2'd0;
            s_bvalid      <= 1'b0;
            s_bresp       <= RESP_OKAY;
            s_rvalid      <= 1'b0;
            s_rdata       <= 32'd0;
            s_rresp       <= RESP_OKAY;
            rfifo_pop     <= 1'b0;
            tfifo_push    <= 1'b0;
            tfifo_data_in <= 32'd0;
            ctrl_mode     <= 3'd0;
        end else begin
            bus_live   <= 1'b1;
            tfifo_push <= 1'b0;
            rfifo_pop  <= 1'b0;

            if (s_awvalid && s_awready) begin
                aw_held <= 1'b1;
                aw_addr <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                w_held <= 1'b1;
                w_data <= s_wdata;
                w_strb <= s_wstrb[1:0];
            end

            if (wr_exec) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= wr_resp;
                if (wr_push) begin
                    tfifo_push    <= 1'b1;
                    tfifo_data_in <= w_data;
                end
                if (wr_ctrl && w_strb[0]) ctrl_mode <= w_data[2:0];
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end

            if (s_arvalid && s_arready) begin
                s_rvalid  <= 1'b1;
                s_rdata   <= rd_data;
                s_rresp   <= rd_resp;
                rfifo_pop <= rd_pop;
            end else if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

`ifdef UART_AXIL_IRQ_MASK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
        end else if (wr_exec && wr_ctrl && w_strb[1]) begin
            irq_en <= w_data[8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= uart_irq && irq_en;
    end
`else
    assign irq_en = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= uart_irq;
    end
`endif

endmodule

// File: tb/tb_uart_axil_regs.sv
// Bench for uart_axil_regs: directed register checks, then randomized traffic against
// a register-level reference model with a scoreboard for pushed words and pops.
module tb_uart_axil_regs;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] s_awaddr = '0;
    logic          s_awvalid = 1'b0;
    logic          s_awready;
    logic [31:0]   s_wdata = 32'd0;
    logic [3:0]    s_wstrb = 4'd0;
    logic          s_wvalid = 1'b0;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready = 1'b0;
    logic [AW-1:0] s_araddr = '0;
    logic          s_arvalid = 1'b0;
    logic          s_arready;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready = 1'b0;
    logic          rfifo_pop;
    logic [31:0]   rfifo_data_out = 32'd0;
    logic          rx_empty = 1'b1;
    logic          tfifo_push;
    logic [31:0]   tfifo_data_in;
    logic          tx_full = 1'b0;
    logic [31:0]   uart_fifo_ctrl;
    logic          uart_irq = 1'b0;
    logic          irq;

    uart_axil_regs #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .rfifo_pop(rfifo_pop), .rfifo_data_out(rfifo_data_out), .rx_empty(rx_empty),
        .tfifo_push(tfifo_push), .tfifo_data_in(tfifo_data_in), .tx_full(tx_full),
        .uart_fifo_ctrl(uart_fifo_ctrl), .uart_irq(uart_irq), .irq(irq)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected pushed words, observed pushed words, pop counts.
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          exp_pops = 0;
    int          pop_cnt = 0;
    logic [31:0] m_ctrl = 32'd0;

    always @(posedge clk) begin
        if (tfifo_push) got_q.push_back(tfifo_data_in);
        if (rfifo_pop) pop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: register map behaviour as a function of address and FIFO state.
    task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] r);
        int idx;
        idx = (int'(a) % 16) / 4;
        if (int'(a) >= 16) r = 2'b11;
        else if (idx == 1) begin
            if (tx_full) r = 2'b10;
            else begin
                r = 2'b00;
                exp_q.push_back(d);
            end
        end else if (idx == 3) begin
            r = 2'b00;
            if (s[0]) m_ctrl[2:0] = d[2:0];
`ifdef UART_AXIL_IRQ_MASK_EN
            if (s[1]) m_ctrl[8] = d[8];
`endif
        end else r = 2'b10;
    endtask

    task automatic model_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
        int idx;
        idx = (int'(a) % 16) / 4;
        d = 32'd0;
        r = 2'b00;
        if (int'(a) >= 16) r = 2'b11;
        else if (idx == 0) begin
            if (!rx_empty) begin
                d = rfifo_data_out;
                exp_pops++;
            end
        end else if (idx == 1) r = 2'b10;
        else if (idx == 2) d = 32'(rx_empty) + 32'(tx_full) * 2 + 32'(uart_irq) * 4;
        else d = m_ctrl;
    endtask

    function automatic logic exp_irq();
`ifdef UART_AXIL_IRQ_MASK_EN
        return uart_irq && m_ctrl[8];
`else
        return uart_irq;
`endif
    endfunction

    // Driver tasks
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output int b_wait, output logic [31:0] ctrl_at_b);
        int cyc;
        bit aw_done, w_done, a_hs, w_hs;
        cyc = 0; aw_done = 0; w_done = 0;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            s_awvalid = !aw_done && cyc >= aw_dly;
            s_wvalid  = !w_done && cyc >= w_dly;
            @(negedge clk);
            a_hs = s_awvalid && s_awready;
            w_hs = s_wvalid && s_wready;
            @(posedge clk); #1;
            if (a_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        check("aw_w_accept", {30'd0, aw_done, w_done}, 32'd3);
        b_wait = 0;
        while (!s_bvalid && b_wait < 20) begin
            @(posedge clk); #1;
            b_wait++;
        end
        check("bvalid_timeout", {31'd0, s_bvalid}, 32'd1);
        resp = s_bresp;
        ctrl_at_b = uart_fifo_ctrl;
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            check("b_hold_valid", {31'd0, s_bvalid}, 32'd1);
            check("b_hold_resp", {30'd0, s_bresp}, {30'd0, resp});
            check("b_hold_awready", {30'd0, s_awready, s_wready}, 32'd0);
            @(posedge clk); #1;
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        bit hs;
        cyc = 0; hs = 0;
        s_araddr = addr;
        s_arvalid = 1'b1;
        while (!hs && cyc < 20) begin
            @(negedge clk);
            hs = s_arready;
            @(posedge clk); #1;
            cyc++;
        end
        s_arvalid = 1'b0;
        check("ar_accept", {31'd0, hs}, 32'd1);
        check("r_latency", {31'd0, s_rvalid}, 32'd1);
        data = s_rdata;
        resp = s_rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check("r_hold_valid", {31'd0, s_rvalid}, 32'd1);
            check("r_hold_data", s_rdata, data);
            check("r_hold_resp", {30'd0, s_rresp}, {30'd0, resp});
            check("r_hold_arready", {31'd0, s_arready}, 32'd0);
            @(posedge clk); #1;
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0]  r_exp, r_got;
        logic [31:0] ctrl_b;
        int          bw;
        model_write(a, d, s, r_exp);
        axi_write(a, d, s, aw_dly, w_dly, b_dly, r_got, bw, ctrl_b);
        check({tag, "_bresp"}, {30'd0, r_got}, {30'd0, r_exp});
        check({tag, "_ctrl_at_b"}, ctrl_b, {29'd0, m_ctrl[2:0]});
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input int r_dly);
        logic [31:0] d_exp, d_got;
        logic [1:0]  r_exp, r_got;
        model_read(a, d_exp, r_exp);
        axi_read(a, r_dly, d_got, r_got);
        check({tag, "_rdata"}, d_got, d_exp);
        check({tag, "_rresp"}, {30'd0, r_got}, {30'd0, r_exp});
    endtask

    task automatic fifo_chk(input string tag);
        @(posedge clk); #1;
        check({tag, "_pops"}, pop_cnt, exp_pops);
        check({tag, "_push_cnt"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_push_data"}, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] c;
        int          bw;
        int          sel;
        logic [AW-1:0] a;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", {31'd0, s_awready}, 32'd0);
        check("rst_wready", {31'd0, s_wready}, 32'd0);
        check("rst_arready", {31'd0, s_arready}, 32'd0);
        check("rst_valids", {30'd0, s_bvalid, s_rvalid}, 32'd0);
        check("rst_resps", {28'd0, s_bresp, s_rresp}, 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_push_pop", {30'd0, tfifo_push, rfifo_pop}, 32'd0);
        check("rst_tdata", tfifo_data_in, 32'd0);
        check("rst_ctrl", uart_fifo_ctrl, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("live_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd7);

        // CTRL write / readback and same-cycle AW+W latency
        axi_write(5'h0C, 32'h0000_0005, 4'h1, 0, 0, 0, r, bw, c);
        m_ctrl[2:0] = 3'd5;
        check("ctrl_bresp", {30'd0, r}, 32'd0);
        check("ctrl_b_latency", bw, 1);
        check("ctrl_at_b", c, 32'd5);
        check("ctrl_out", uart_fifo_ctrl, 32'd5);
        rd_chk("ctrl_rd", 5'h0C, 0);
        wr_chk("ctrl_nostrb", 5'h0C, 32'h0000_0002, 4'hE, 0, 0, 0);
        check("ctrl_nostrb_out", uart_fifo_ctrl, 32'd5);

        // RXDATA
        rx_empty = 1'b0; rfifo_data_out = 32'hDEAD_BEEF;
        rd_chk("rx_full", 5'h00, 0);
        fifo_chk("rx_full");
        rx_empty = 1'b1;
        rd_chk("rx_empty", 5'h00, 0);
        fifo_chk("rx_empty");

        // TXDATA with W leading AW by 3 cycles
        tx_full = 1'b0;
        wr_chk("tx_ok", 5'h04, 32'h1234_5678, 4'h0, 3, 0, 0);
        fifo_chk("tx_ok");
        tx_full = 1'b1;
        wr_chk("tx_full", 5'h04, 32'hCAFE_0001, 4'hF, 3, 0, 0);
        fifo_chk("tx_full");
        tx_full = 1'b0;

        // Unmapped, STATUS, read of TXDATA, write of RO registers
        rx_empty = 1'b0;
        rd_chk("unmapped_rd", 5'h10, 0);
        wr_chk("unmapped_wr", 5'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        rd_chk("tx_rd", 5'h04, 0);
        wr_chk("rx_wr", 5'h00, 32'h1, 4'hF, 0, 0, 0);
        tx_full = 1'b1; uart_irq = 1'b1;
        rd_chk("status_rd", 5'h08, 0);
        wr_chk("status_wr", 5'h08, 32'h7, 4'hF, 0, 0, 0);
        fifo_chk("decode");

        // Backpressure on both response channels
        tx_full = 1'b0; rfifo_data_out = 32'hA5A5_0F0F;
        rd_chk("bp_rd", 5'h00, 5);
        wr_chk("bp_wr", 5'h04, 32'h0BAD_F00D, 4'hF, 0, 0, 5);
        fifo_chk("bp");

        // Interrupt masking
        uart_irq = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("irq_pre", {31'd0, irq}, {31'd0, exp_irq()});
        wr_chk("irq_en_wr", 5'h0C, 32'h0000_0100, 4'h2, 0, 0, 0);
        @(posedge clk); #1;
        check("irq_post", {31'd0, irq}, {31'd0, exp_irq()});
        rd_chk("irq_ctrl_rd", 5'h0C, 0);
        uart_irq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("irq_low", {31'd0, irq}, 32'd0);

        // Reset asserted during the execute cycle of a TXDATA write
        tx_full = 1'b0;
        s_awaddr = 5'h04; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        rst_n = 1'b0;
        m_ctrl = 32'd0;
        #1;
        check("midrst_bvalid", {31'd0, s_bvalid}, 32'd0);
        check("midrst_ctrl", uart_fifo_ctrl, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_bvalid_after", {31'd0, s_bvalid}, 32'd0);
        fifo_chk("midrst");
        rd_chk("midrst_ctrl_rd", 5'h0C, 0);

        // Randomized traffic against the reference model
        for (int it = 0; it < 60; it++) begin
            rx_empty       = 1'($urandom_range(0, 1));
            tx_full        = 1'($urandom_range(0, 1));
            uart_irq       = 1'($urandom_range(0, 1));
            rfifo_data_out = $urandom;
            sel = $urandom_range(0, 5);
            if (sel < 4) a = AW'(sel * 4 + $urandom_range(0, 3));
            else if (sel == 4) a = AW'(16 + $urandom_range(0, 15));
            else a = AW'($urandom_range(0, 31));
            @(posedge clk); #1;
            if ($urandom_range(0, 1) == 1)
                wr_chk("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                rd_chk("rnd_rd", a, $urandom_range(0, 2));
            fifo_chk("rnd");
            check("rnd_ctrl_out", uart_fifo_ctrl, {29'd0, m_ctrl[2:0]});
            check("rnd_irq", {31'd0, irq}, {31'd0, exp_irq()});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
